// File: rtl/nn_pkg.sv
// Shared types and constants for the softmax network output stages.
package nn_pkg;

  localparam int SCORE_W    = 18;
  localparam int SCORE_FRAC = 8;

  typedef logic signed [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  // Converts a value given in thousandths into fixed point with frac fractional bits.
  function automatic int to_fixed_const(input int milli, input int frac);
    return (milli * (1 << frac)) / 1000;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare/select cell for a running argmax.
module argmax_cmp #(
  parameter int WIDTH = 18,
  parameter int IDXW  = 4
) (
  input  logic signed [WIDTH-1:0] run_max,
  input  logic        [IDXW-1:0]  run_idx,
  input  logic signed [WIDTH-1:0] score,
  input  logic        [IDXW-1:0]  idx,
  input  logic                    first,
  output logic signed [WIDTH-1:0] new_max,
  output logic        [IDXW-1:0]  new_idx
);

  // First element seeds the max; afterwards only a strictly larger score wins, so ties keep the lower index.
  always_comb begin
    new_max = run_max;
    new_idx = run_idx;
    if (first || (score > run_max)) begin
      new_max = score;
      new_idx = idx;
    end
  end

endmodule

// File: rtl/softmax_argmax_stream.sv
// Streaming argmax over softmax score frames with per-batch result counting.
module softmax_argmax_stream
  import nn_pkg::*;
#(
  parameter int OUT_SIZE = 10,
  parameter int WIDTH    = SCORE_W,
  parameter int FRAC     = SCORE_FRAC,
  parameter int BATCH    = 300,
  parameter int THRESH   = to_fixed_const(500, FRAC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_score,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(OUT_SIZE)-1:0] out_class,
  output logic signed [WIDTH-1:0]     out_score,
  output logic [$clog2(BATCH)-1:0]    out_sample,
  output logic                        out_confident,
  output logic                        batch_done,
  output logic                        frame_err
);

  localparam int CW = $clog2(OUT_SIZE);
  localparam int SW = $clog2(BATCH);
  localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESH);

  argmax_state_e state;
  logic [CW-1:0] class_cnt;
  logic [SW-1:0] sample_cnt;
  logic signed [WIDTH-1:0] run_max;
  logic [CW-1:0] run_idx;
  logic signed [WIDTH-1:0] nmax;
  logic [CW-1:0] nidx;
  logic accept;
  logic consume;
  logic at_last;
  logic last_sample;

  assign accept      = in_valid && in_ready;
  assign consume     = out_valid && out_ready;
  assign at_last     = (class_cnt == CW'(OUT_SIZE - 1));
  assign last_sample = (sample_cnt == SW'(BATCH - 1));

  argmax_cmp #(
    .WIDTH (WIDTH),
    .IDXW  (CW)
  ) u_cmp (
    .run_max (run_max),
    .run_idx (run_idx),
    .score   (in_score),
    .idx     (class_cnt),
    .first   (class_cnt == '0),
    .new_max (nmax),
    .new_idx (nidx)
  );

  // Frame/batch FSM; handshake flags are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state         <= SCAN;
      class_cnt     <= '0;
      sample_cnt    <= '0;
      run_max       <= '0;
      run_idx       <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_class     <= '0;
      out_score     <= '0;
      out_sample    <= '0;
      out_confident <= 1'b0;
      batch_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      unique case (state)
        SCAN: begin
          if (accept) begin
            run_max <= nmax;
            run_idx <= nidx;
            // Framing follows the element count; in_last is only checked against it.
            if (in_last != at_last) frame_err <= 1'b1;
            if (at_last) begin
              class_cnt     <= '0;
              out_class     <= nidx;
              out_score     <= nmax;
              out_sample    <= sample_cnt;
              out_confident <= (nmax >= THR);
              in_ready      <= 1'b0;
              out_valid     <= 1'b1;
              state         <= HOLD;
            end else begin
              class_cnt <= class_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (consume) begin
            out_valid <= 1'b0;
            if (last_sample) begin
              batch_done <= 1'b1;
              state      <= DONE;
            end else begin
              sample_cnt <= sample_cnt + SW'(1);
              in_ready   <= 1'b1;
              state      <= SCAN;
            end
          end
        end
        DONE: begin
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_argmax_stream.sv
// Self-checking bench for softmax_argmax_stream (OUT_SIZE=3, BATCH=4).
module tb_softmax_argmax_stream;
  import nn_pkg::*;

  localparam int OUT_SIZE = 3;
  localparam int BATCH    = 4;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, in_ready, in_last, out_valid, out_ready;
  score_t in_score, out_score;
  logic [1:0] out_class;
  logic [1:0] out_sample;
  logic out_confident, batch_done, frame_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    score_t s0, s1, s2;
    int     cls;
    int     score;
    bit     conf;
  } vec_t;

  typedef struct {
    int cls;
    int score;
    int sample;
    bit conf;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];

  softmax_argmax_stream #(
    .OUT_SIZE (OUT_SIZE),
    .WIDTH    (18),
    .FRAC     (8),
    .BATCH    (BATCH),
    .THRESH   (128)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_score      (in_score),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_class     (out_class),
    .out_score     (out_score),
    .out_sample    (out_sample),
    .out_confident (out_confident),
    .batch_done    (batch_done),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " in_ready"}, int'(in_ready), 1);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_class"}, int'(out_class), 0);
    chk({tag, " out_score"}, int'(out_score), 0);
    chk({tag, " out_sample"}, int'(out_sample), 0);
    chk({tag, " out_confident"}, int'(out_confident), 0);
    chk({tag, " batch_done"}, int'(batch_done), 0);
    chk({tag, " frame_err"}, int'(frame_err), 0);
  endtask

  // Called at a negedge; returns at the negedge after the element is accepted.
  task automatic send(input score_t s, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_score = s;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic frame(input score_t s0, input score_t s1, input score_t s2,
                       input bit l0, input bit l1, input bit l2,
                       input int cls, input int score, input int sample, input bit conf);
    exp_t e;
    send(s0, l0);
    send(s1, l1);
    send(s2, l2);
    e.cls = cls; e.score = score; e.sample = sample; e.conf = conf;
    sb.push_back(e);
    chk("latency out_valid", int'(out_valid), 1);
    chk("hold in_ready", int'(in_ready), 0);
  endtask

  task automatic get_result();
    exp_t e;
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50 || sb.size() == 0) begin
      chk("result timeout", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("out_class", int'(out_class), e.cls);
      chk("out_score", int'(out_score), e.score);
      chk("out_sample", int'(out_sample), e.sample);
      chk("out_confident", int'(out_confident), int'(e.conf));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{s0: 26,   s1: 179,  s2: 51,  cls: 1, score: 179, conf: 1'b1};
    vecs[1] = '{s0: 100,  s1: 100,  s2: 50,  cls: 0, score: 100, conf: 1'b0};
    vecs[2] = '{s0: -5,   s1: -3,   s2: -9,  cls: 1, score: -3,  conf: 1'b0};
    vecs[3] = '{s0: 128,  s1: -200, s2: 127, cls: 0, score: 128, conf: 1'b1};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_score = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // Full batch from the vector table.
    for (int i = 0; i < 4; i++) begin
      frame(vecs[i].s0, vecs[i].s1, vecs[i].s2, 1'b0, 1'b0, 1'b1,
            vecs[i].cls, vecs[i].score, i, vecs[i].conf);
      get_result();
    end
    chk("done batch_done", int'(batch_done), 1);
    chk("done in_ready", int'(in_ready), 0);
    chk("done out_valid", int'(out_valid), 0);
    in_valid = 1'b1; in_score = 18'sd7;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("done stays", int'(batch_done), 1);
    chk("done in_ready stays", int'(in_ready), 0);
    pulse_clear();
    check_idle("clear after done");

    // Backpressure: result held, extra input refused.
    frame(18'sd5, 18'sd300, 18'sd7, 1'b0, 1'b0, 1'b1, 1, 300, 0, 1'b1);
    in_valid = 1'b1; in_score = 18'sd999; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp out_score", int'(out_score), 300);
      chk("bp out_class", int'(out_class), 1);
    end
    in_valid = 1'b0;
    get_result();
    frame(18'sd1, 18'sd2, 18'sd3, 1'b0, 1'b0, 1'b1, 2, 3, 1, 1'b0);
    get_result();

    // Early in_last.
    pulse_clear();
    send(18'sd10, 1'b1);
    chk("early last frame_err", int'(frame_err), 1);
    send(18'sd20, 1'b0);
    send(18'sd15, 1'b1);
    sb.push_back('{cls: 1, score: 20, sample: 0, conf: 1'b0});
    chk("early last out_valid", int'(out_valid), 1);
    get_result();
    chk("frame_err sticky", int'(frame_err), 1);

    // Missing in_last.
    pulse_clear();
    chk("clear frame_err", int'(frame_err), 0);
    frame(18'sd1, 18'sd2, 18'sd3, 1'b0, 1'b0, 1'b0, 2, 3, 0, 1'b0);
    chk("missing last frame_err", int'(frame_err), 1);
    get_result();

    // Reset mid-frame.
    send(18'sd50, 1'b0);
    send(18'sd60, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("mid-frame reset");
    frame(-18'sd1, -18'sd2, 18'sd40, 1'b0, 1'b0, 1'b1, 2, 40, 0, 1'b0);
    get_result();

    chk("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/softmax_argmax_stream.md
Name: softmax_argmax_stream

Overview:
- Sequential classifier stage directly downstream of the 2-/3-layer softmax network.
- Consumes the softmax score vector one element per cycle over a valid/ready stream.
- Produces per-sample predicted class index, winning score and sample number over a valid/ready result port.
- Replaces the bench-side argmax loop with synthesizable RTL, and flags the end of a batch and framing errors.

Parameters:
- OUT_SIZE, 10, number of classes per sample (scores per frame); must be >= 2.
- WIDTH, 18, signed fixed-point score width.
- FRAC, 8, fractional bits of the score (used only for THRESH interpretation).
- BATCH, 300, samples per batch before batch_done.
- THRESH, 128, signed confidence threshold in WIDTH/FRAC format (128 = 0.5).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous restart pulse: returns the block to the reset state without reset
- in_valid  in  1  score element valid
- in_ready  out  1  block accepts a score element
- in_score  in  WIDTH  signed softmax score
- in_last  in  1  marks the final element of a frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_class  out  $clog2(OUT_SIZE)  argmax index
- out_score  out  WIDTH  winning score
- out_sample  out  $clog2(BATCH)  sample number within the batch, 0-based
- out_confident  out  1  out_score >= THRESH (signed compare)
- batch_done  out  1  high after BATCH results have been accepted
- frame_err  out  1  sticky in_last framing error

Behaviour:
- Reset/clear:
  - rst_n=0 or clear=1 at a rising edge → state SCAN, class_cnt=0, sample_cnt=0.
  - All outputs 0 except in_ready=1: out_valid, out_class, out_score, out_sample, out_confident, batch_done and frame_err are all 0.
  - clear has priority over any handshake in the same cycle; an accepted element or result in that cycle is discarded.
- States:
  - SCAN: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - DONE: in_ready=0, out_valid=0, batch_done=1.
- Accept rule: an element is accepted when in_valid && in_ready at a rising edge. A result is consumed when out_valid && out_ready.
- SCAN, element at class_cnt==0: run_max := in_score, run_idx := 0 unconditionally.
- SCAN, element at class_cnt>0: if in_score > run_max (strict signed compare), update run_max and run_idx. Ties keep the lower index.
- SCAN, after each accept: class_cnt increments.
- SCAN → HOLD when the accepted element has class_cnt==OUT_SIZE-1:
  - Result registers are loaded with the final compare, including this element.
  - out_sample := sample_cnt; out_confident := final max >= THRESH.
  - class_cnt := 0.
  - out_valid rises the cycle after the last element is accepted (latency 1).
- Framing errors:
  - in_last==1 on an accept with class_cnt != OUT_SIZE-1 → frame_err := 1.
  - in_last==0 on the accept of element OUT_SIZE-1 → frame_err := 1.
  - In both cases framing proceeds by count, not by in_last.
  - frame_err clears only on reset or clear.
- HOLD:
  - Outputs stay stable while out_ready=0.
  - On consume: if sample_cnt==BATCH-1 → DONE, else sample_cnt++ and → SCAN.
  - in_ready is 0 for the whole HOLD cycle, so there is one bubble per sample.
- DONE: holds until rst_n or clear; in_valid is ignored.
- Counter width rules: counters never wrap past OUT_SIZE-1 / BATCH-1. Comparisons are full-width signed; no saturation needed.

Decomposition:
- Package nn_pkg:
  - score_t: logic signed [WIDTH-1:0] with default WIDTH/FRAC.
  - Enum argmax_state_e {SCAN, HOLD, DONE}.
  - Helper function to_fixed_const for THRESH derivation.
- Sub-module argmax_cmp: a pure combinational compare/select cell that takes (run_max, run_idx, score, idx, first) and returns the new max/idx.
- The FSM and counters live in the top module.

Test Plan:
- OUT_SIZE=3, scores {0.1, 0.7, 0.2} (26, 179, 51), in_last on 3rd → one cycle later out_valid=1, out_class=1, out_score=179, out_confident=1, out_sample=0.
- Tie: scores {100, 100, 50} → out_class=0. All-negative {-5, -3, -9} → out_class=1, out_score=-3, out_confident=0.
- Backpressure: hold out_ready=0 for 5 cycles → outputs stable, in_ready=0, extra in_valid is not accepted; release → next sample accepted with out_sample=1.
- BATCH=4: four frames with results accepted → batch_done=1 and in_ready=0 the cycle after the 4th consume; clear → batch_done=0, in_ready=1, sample_cnt=0.
- in_last asserted on element 1 of 3 → frame_err=1 (sticky); the result still appears after the 3rd element.
- rst_n=0 mid-frame after 2 elements → all outputs 0, in_ready=1; next full frame yields out_sample=0 with correct argmax.
